memory_read_responder: RTL and testbench

Shared instruction-memory responder sitting at the far end of the `memory_read_iface` links driven by the engines. It arbitrates N_PORTS read requesters round-robin and issues one read per cycle to a single-port synchronous program memory. It broadcasts the returned word on a shared data bus and pulses `ready` only to the port whose read is being delivered; that port alone knows it won arbitration.

---
 rtl/memory_read_responder_pkg.sv | 30 +++
 rtl/memory_read_responder_if.sv | 26 ++
 rtl/memory_read_responder_rr_arbiter.sv | 51 +++++
 rtl/memory_read_responder.sv | 90 +++++++++
 tb/tb_memory_read_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_read_responder_pkg.sv
// Shared constants and tag type for the instruction-memory read responder.
// Provides: port count, data/address widths, port-id width, mem_tag_t, onehot_to_id().
package memory_responder_pkg;

    localparam int unsigned N_PORTS           = 4;
    localparam int unsigned MEMORY_WIDTH      = 16;
    localparam int unsigned MEMORY_ADDR_WIDTH = 11;
    localparam int unsigned PORT_ID_W         = (N_PORTS > 2) ? $clog2(N_PORTS) : 1;

    typedef logic [PORT_ID_W-1:0] port_id_t;

    // Identifies which port owns the read travelling through the memory latency pipe.
    typedef struct packed {
        logic     valid;
        port_id_t id;
    } mem_tag_t;

    // Encodes a one-hot (or all-zero) port vector into its port index.
    function automatic port_id_t onehot_to_id(input logic [N_PORTS-1:0] oh);
        port_id_t id;
        id = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (oh[i]) begin
                id = id | PORT_ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/memory_read_responder_if.sv
// Request/response link between the engines and the shared memory responder.
// Signals: req_valid/req_addr (engine -> responder), req_ready/rsp_data (responder -> engine).
// Modports: master (engine side), slave (responder side).
interface memory_read_iface;
    import memory_responder_pkg::*;

    logic [N_PORTS-1:0]                   req_valid;
    logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] req_addr;
    logic [N_PORTS-1:0]                   req_ready;
    logic [MEMORY_WIDTH-1:0]              rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_data
    );

endinterface

// File: rtl/memory_read_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among request bits, searching from the
// pointer upward and wrapping; pointer moves to the slot after each grant.
// Ports: clk, rst (async active-low), request[N], enable, grant[N] (combinational).
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request,
    input  logic         enable,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 2) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // Two passes: ports at or above the pointer first, then the wrapped-around ones.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        if (enable) begin
            for (int unsigned p = 0; p < N; p++) begin
                if (!found && request[p] && (32'(ptr_q) <= p)) begin
                    grant[p] = 1'b1;
                    ptr_d    = PW'((p + 1) % N);
                    found    = 1'b1;
                end
            end
            for (int unsigned p = 0; p < N; p++) begin
                if (!found && request[p]) begin
                    grant[p] = 1'b1;
                    ptr_d    = PW'((p + 1) % N);
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/memory_read_responder.sv
// Shared instruction-memory responder: arbitrates N_PORTS readers round-robin,
// issues one read per cycle to a synchronous memory, and returns each word to
// its requester after MEM_LATENCY cycles with a one-hot req_ready pulse.
// Ports: clk, rst (async active-low), bus (slave side of memory_read_iface),
//        mem_en/mem_addr (to memory), mem_data (from memory), protocol_err (sticky).
module memory_read_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    memory_read_iface.slave              bus,
    output logic                         mem_en,
    output logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEMORY_WIDTH-1:0]      mem_data,
    output logic                         protocol_err
);

    logic [N_PORTS-1:0]      outstanding_q;
    logic [N_PORTS-1:0]      eligible;
    logic [N_PORTS-1:0]      grant;
    logic [N_PORTS-1:0]      deliver;
    logic [MEMORY_WIDTH-1:0] rsp_data_c;
    mem_tag_t                tag_in;
    mem_tag_t                tag_out;
    mem_tag_t                pipe_q [MEM_LATENCY];

    // A port with a read in flight is excluded until the cycle after its delivery.
    assign eligible = bus.req_valid & ~outstanding_q;

    // Reset doubles as the grant enable so the memory sees no read while reset is held.
    rr_arbiter #(
        .N(N_PORTS)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .request(eligible),
        .enable (rst),
        .grant  (grant)
    );

    // Address mux and tag for the read issued this cycle.
    always_comb begin
        mem_en   = |grant;
        mem_addr = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                mem_addr = bus.req_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
        tag_in.valid = mem_en;
        tag_in.id    = onehot_to_id(grant);
    end

    // Response gating: data is forwarded only while a valid tag leaves the pipe.
    always_comb begin
        tag_out    = pipe_q[MEM_LATENCY-1];
        deliver    = '0;
        rsp_data_c = '0;
        if (tag_out.valid) begin
            deliver    = N_PORTS'(1) << tag_out.id;
            rsp_data_c = mem_data;
        end
    end

    assign bus.req_ready = deliver;
    assign bus.rsp_data  = rsp_data_c;

    // Tag pipe, in-flight mask and sticky protocol error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
            protocol_err  <= 1'b0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            outstanding_q <= (outstanding_q | grant) & ~deliver;
            if (|(outstanding_q & ~bus.req_valid)) begin
                protocol_err <= 1'b1;
            end
            pipe_q[0] <= tag_in;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_memory_read_responder.sv
// Directed bench for memory_read_responder: one instance at MEM_LATENCY=1 (dut_a)
// and one at MEM_LATENCY=2 (dut_b), each with its own behavioural memory.
module tb_memory_read_responder;
    import memory_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    memory_read_iface bus_a ();
    memory_read_iface bus_b ();

    logic        mem_en_a, mem_en_b;
    logic [10:0] mem_addr_a, mem_addr_b;
    logic [15:0] mem_data_a, mem_data_b;
    logic [15:0] rd_b1;
    logic        perr_a, perr_b;

    logic [15:0] mem [2048];

    int tests_run    = 0;
    int tests_failed = 0;

    memory_read_responder #(.MEM_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst_a), .bus(bus_a),
        .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .protocol_err(perr_a)
    );

    memory_read_responder #(.MEM_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .protocol_err(perr_b)
    );

    // Synchronous memories: latency 1 for dut_a, latency 2 for dut_b.
    always @(posedge clk) begin
        mem_data_a <= mem_en_a ? mem[mem_addr_a] : 16'hDEAD;
        rd_b1      <= mem_en_b ? mem[mem_addr_b] : 16'hDEAD;
        mem_data_b <= rd_b1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.req_valid = 4'b1111;
        bus_a.req_addr  = '1;
        bus_b.req_valid = '0;
        bus_b.req_addr  = '0;
        #20;
        tests_run++; if (bus_a.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b exp 0000", bus_a.req_ready); end
        tests_run++; if (bus_a.rsp_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_data: got %h exp 0000", bus_a.rsp_data); end
        tests_run++; if (mem_en_a !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got %b exp 0", mem_en_a); end
        tests_run++; if (mem_addr_a !== 11'h000) begin tests_failed++; $display("FAIL reset_mem_addr: got %h exp 000", mem_addr_a); end
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b exp 0", perr_a); end
        bus_a.req_valid = '0;
        bus_a.req_addr  = '0;
        next_cycle();
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    task automatic test_single();
        bus_a.req_valid = 4'b0100;
        bus_a.req_addr[2*11 +: 11] = 11'h005;
        @(negedge clk);
        tests_run++; if (mem_en_a !== 1'b1) begin tests_failed++; $display("FAIL single_mem_en: got %b exp 1", mem_en_a); end
        tests_run++; if (mem_addr_a !== 11'h005) begin tests_failed++; $display("FAIL single_mem_addr: got %h exp 005", mem_addr_a); end
        tests_run++; if (bus_a.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_early_ready: got %b exp 0000", bus_a.req_ready); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (bus_a.req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b exp 0100", bus_a.req_ready); end
        tests_run++; if (bus_a.rsp_data !== 16'hBEEF) begin tests_failed++; $display("FAIL single_data: got %h exp beef", bus_a.rsp_data); end
        tests_run++; if (mem_en_a !== 1'b0) begin tests_failed++; $display("FAIL single_no_regrant: got %b exp 0", mem_en_a); end
        next_cycle();
        bus_a.req_valid = '0;
        @(negedge clk);
        tests_run++; if (bus_a.rsp_data !== 16'h0000) begin tests_failed++; $display("FAIL single_idle_data: got %h exp 0000", bus_a.rsp_data); end
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL single_perr: got %b exp 0", perr_a); end
        next_cycle();
    endtask

    task automatic test_all_four();
        logic [3:0]  exp_ready;
        logic [15:0] exp_data;
        rst_a = 1'b0;
        #1;
        rst_a = 1'b1;
        for (int i = 0; i < 4; i++) bus_a.req_addr[i*11 +: 11] = 11'(16 + i);
        bus_a.req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                tests_run++; if (mem_en_a !== 1'b1 || mem_addr_a !== 11'(16 + c)) begin tests_failed++; $display("FAIL all4_grant c%0d: got en %b addr %h exp en 1 addr %h", c, mem_en_a, mem_addr_a, 11'(16 + c)); end
            end else begin
                tests_run++; if (mem_en_a !== 1'b0) begin tests_failed++; $display("FAIL all4_idle: got en %b exp 0", mem_en_a); end
            end
            exp_ready = (c >= 1) ? 4'(1 << (c - 1)) : 4'b0000;
            exp_data  = (c >= 1) ? mem[15 + c] : 16'h0000;
            tests_run++; if (bus_a.req_ready !== exp_ready || bus_a.rsp_data !== exp_data) begin tests_failed++; $display("FAIL all4_resp c%0d: got %b/%h exp %b/%h", c, bus_a.req_ready, bus_a.rsp_data, exp_ready, exp_data); end
            next_cycle();
            if (c >= 1) bus_a.req_valid[c - 1] = 1'b0;
        end
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL all4_perr: got %b exp 0", perr_a); end
    endtask

    task automatic test_hold_regrant();
        bus_a.req_valid = 4'b0010;
        bus_a.req_addr[1*11 +: 11] = 11'h020;
        @(negedge clk);
        tests_run++; if (mem_en_a !== 1'b1 || mem_addr_a !== 11'h020) begin tests_failed++; $display("FAIL hold_grant1: got en %b addr %h exp en 1 addr 020", mem_en_a, mem_addr_a); end
        next_cycle();
        bus_a.req_addr[1*11 +: 11] = 11'h021;
        @(negedge clk);
        tests_run++; if (bus_a.req_ready !== 4'b0010 || bus_a.rsp_data !== mem[32]) begin tests_failed++; $display("FAIL hold_ready1: got %b/%h exp 0010/%h", bus_a.req_ready, bus_a.rsp_data, mem[32]); end
        tests_run++; if (mem_en_a !== 1'b0) begin tests_failed++; $display("FAIL hold_stale_regrant: got en %b exp 0", mem_en_a); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (mem_en_a !== 1'b1 || mem_addr_a !== 11'h021) begin tests_failed++; $display("FAIL hold_grant2: got en %b addr %h exp en 1 addr 021", mem_en_a, mem_addr_a); end
        tests_run++; if (bus_a.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL hold_gap_ready: got %b exp 0000", bus_a.req_ready); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (bus_a.req_ready !== 4'b0010 || bus_a.rsp_data !== mem[33]) begin tests_failed++; $display("FAIL hold_ready2: got %b/%h exp 0010/%h", bus_a.req_ready, bus_a.rsp_data, mem[33]); end
        next_cycle();
        bus_a.req_valid = '0;
        @(negedge clk);
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL hold_perr: got %b exp 0", perr_a); end
        next_cycle();
    endtask

    task automatic test_protocol_err();
        bus_a.req_valid = 4'b0001;
        bus_a.req_addr[0 +: 11] = 11'h040;
        @(negedge clk);
        tests_run++; if (mem_en_a !== 1'b1 || mem_addr_a !== 11'h040) begin tests_failed++; $display("FAIL perr_grant: got en %b addr %h exp en 1 addr 040", mem_en_a, mem_addr_a); end
        next_cycle();
        bus_a.req_valid = '0;
        @(negedge clk);
        tests_run++; if (bus_a.req_ready !== 4'b0001 || bus_a.rsp_data !== mem[64]) begin tests_failed++; $display("FAIL perr_still_ready: got %b/%h exp 0001/%h", bus_a.req_ready, bus_a.rsp_data, mem[64]); end
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL perr_early: got %b exp 0", perr_a); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (perr_a !== 1'b1) begin tests_failed++; $display("FAIL perr_set: got %b exp 1", perr_a); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        tests_run++; if (perr_a !== 1'b1) begin tests_failed++; $display("FAIL perr_sticky: got %b exp 1", perr_a); end
        rst_a = 1'b0;
        #1;
        tests_run++; if (perr_a !== 1'b0) begin tests_failed++; $display("FAIL perr_clear: got %b exp 0", perr_a); end
        rst_a = 1'b1;
        next_cycle();
    endtask

    task automatic test_latency2();
        logic        exp_en;
        logic [10:0] exp_addr;
        logic [3:0]  exp_ready;
        logic [15:0] exp_data;
        bus_b.req_addr[0 +: 11]    = 11'h030;
        bus_b.req_addr[3*11 +: 11] = 11'h033;
        bus_b.req_valid = 4'b1001;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            exp_en    = (c % 3) != 2;
            exp_addr  = ((c % 3) == 0) ? 11'h030 : (((c % 3) == 1) ? 11'h033 : 11'h000);
            exp_ready = ((c % 3) == 2) ? 4'b0001 : ((((c % 3) == 0) && (c > 0)) ? 4'b1000 : 4'b0000);
            exp_data  = (exp_ready == 4'b0001) ? mem[48] : ((exp_ready == 4'b1000) ? mem[51] : 16'h0000);
            tests_run++; if (mem_en_b !== exp_en || mem_addr_b !== exp_addr) begin tests_failed++; $display("FAIL lat2_grant c%0d: got en %b addr %h exp en %b addr %h", c, mem_en_b, mem_addr_b, exp_en, exp_addr); end
            tests_run++; if (bus_b.req_ready !== exp_ready || bus_b.rsp_data !== exp_data) begin tests_failed++; $display("FAIL lat2_resp c%0d: got %b/%h exp %b/%h", c, bus_b.req_ready, bus_b.rsp_data, exp_ready, exp_data); end
            next_cycle();
        end
        tests_run++; if (perr_b !== 1'b0) begin tests_failed++; $display("FAIL lat2_perr: got %b exp 0", perr_b); end
        rst_b = 1'b0;
        bus_b.req_valid = '0;
        #1;
        rst_b = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset_inflight();
        bus_b.req_addr[1*11 +: 11] = 11'h051;
        bus_b.req_addr[2*11 +: 11] = 11'h052;
        bus_b.req_valid = 4'b0110;
        @(negedge clk);
        tests_run++; if (mem_en_b !== 1'b1 || mem_addr_b !== 11'h051) begin tests_failed++; $display("FAIL rstf_grant1: got en %b addr %h exp en 1 addr 051", mem_en_b, mem_addr_b); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (mem_en_b !== 1'b1 || mem_addr_b !== 11'h052) begin tests_failed++; $display("FAIL rstf_grant2: got en %b addr %h exp en 1 addr 052", mem_en_b, mem_addr_b); end
        #1;
        rst_b = 1'b0;
        #1;
        tests_run++; if (mem_en_b !== 1'b0 || mem_addr_b !== 11'h000) begin tests_failed++; $display("FAIL rstf_mem_zero: got en %b addr %h exp en 0 addr 000", mem_en_b, mem_addr_b); end
        tests_run++; if (bus_b.req_ready !== 4'b0000 || bus_b.rsp_data !== 16'h0000 || perr_b !== 1'b0) begin tests_failed++; $display("FAIL rstf_out_zero: got %b/%h/%b exp 0000/0000/0", bus_b.req_ready, bus_b.rsp_data, perr_b); end
        bus_b.req_valid = '0;
        next_cycle();
        rst_b = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++; if (bus_b.req_ready !== 4'b0000 || mem_en_b !== 1'b0) begin tests_failed++; $display("FAIL rstf_no_delivery c%0d: got ready %b en %b exp 0000/0", c, bus_b.req_ready, mem_en_b); end
            next_cycle();
        end
        bus_b.req_addr[2*11 +: 11] = 11'h062;
        bus_b.req_addr[3*11 +: 11] = 11'h063;
        bus_b.req_valid = 4'b1100;
        @(negedge clk);
        tests_run++; if (mem_en_b !== 1'b1 || mem_addr_b !== 11'h062) begin tests_failed++; $display("FAIL rstf_first_grant: got en %b addr %h exp en 1 addr 062", mem_en_b, mem_addr_b); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (mem_addr_b !== 11'h063 || bus_b.req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rstf_second_grant: got addr %h ready %b exp 063/0000", mem_addr_b, bus_b.req_ready); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (bus_b.req_ready !== 4'b0100 || bus_b.rsp_data !== mem[98]) begin tests_failed++; $display("FAIL rstf_first_ready: got %b/%h exp 0100/%h", bus_b.req_ready, bus_b.rsp_data, mem[98]); end
        rst_b = 1'b0;
        bus_b.req_valid = '0;
        #1;
        rst_b = 1'b1;
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 37 + 16'h1000);
        mem[5] = 16'hBEEF;
        test_reset();
        test_single();
        test_all_four();
        test_hold_regrant();
        test_protocol_err();
        test_latency2();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
